// File: rtl/l1tag_pkg.sv
// Shared constants, flush-state type and width helpers for the L1 tag array.
// The optional flush engine is enabled with the L1TAG_FLUSH_EN macro.
package l1tag_pkg;

    localparam int unsigned L1TAG_ADDR_W     = 32;
    localparam int unsigned L1TAG_LINE_W     = 7;
    localparam int unsigned L1TAG_SET_W      = 5;
    localparam int unsigned L1TAG_WAYS       = 4;
    localparam int unsigned L1TAG_SEG_W      = 5;
    localparam logic [9:0]  L1TAG_HIT_DELAY  = 10'd2;
    localparam logic [9:0]  L1TAG_MISS_DELAY = 10'd100;

    typedef enum logic [0:0] {
        FLUSH_IDLE = 1'b0,
        FLUSH_RUN  = 1'b1
    } flush_state_e;

    // Way-index / age width; a direct-mapped array still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned line_w,
                                          input int unsigned set_w, input int unsigned seg_w);
        return seg_w + addr_w - line_w - set_w;
    endfunction

endpackage

// File: rtl/l1tag_lru_set.sv
// Combinational age-counter LRU update and fill-victim choice for one set.
module l1tag_lru_set
    import l1tag_pkg::*;
#(
    parameter int unsigned WAYS  = L1TAG_WAYS,
    parameter int unsigned IDX_W = idx_w(WAYS)
) (
    input  logic [WAYS-1:0][IDX_W-1:0] age_i,
    input  logic [WAYS-1:0]            valid_i,
    input  logic                       touch_en_i,
    input  logic [IDX_W-1:0]           touch_way_i,
    output logic [WAYS-1:0][IDX_W-1:0] age_c,
    output logic [IDX_W-1:0]           victim_c
);

    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(WAYS - 1);

    logic [IDX_W-1:0] touch_age;
    logic             found_inv;
    logic             found_old;

    // Touched way becomes MRU; only ways younger than it age by one.
    always_comb begin
        touch_age = age_i[touch_way_i];
        age_c     = age_i;
        if (touch_en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (IDX_W'(w) == touch_way_i) begin
                    age_c[w] = '0;
                end else if (age_i[w] < touch_age) begin
                    age_c[w] = (age_i[w] == AGE_MAX) ? AGE_MAX : age_i[w] + 1'b1;
                end
            end
        end
    end

    // Prefer the lowest invalid way, else the oldest one.
    always_comb begin
        victim_c  = '0;
        found_inv = 1'b0;
        found_old = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_i[w]) begin
                victim_c  = IDX_W'(w);
                found_inv = 1'b1;
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!found_old && age_i[w] == AGE_MAX) begin
                    victim_c  = IDX_W'(w);
                    found_old = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/l1_tag_assoc.sv
// Set-associative L1 tag array with 1-cycle lookup, 1-cycle fill and age-based LRU.
// Define L1TAG_FLUSH_EN to add the flush / flush_busy set-by-set invalidation engine.
module l1_tag_assoc
    import l1tag_pkg::*;
#(
    parameter int unsigned ADDR_W     = L1TAG_ADDR_W,
    parameter int unsigned LINE_W     = L1TAG_LINE_W,
    parameter int unsigned SET_W      = L1TAG_SET_W,
    parameter int unsigned WAYS       = L1TAG_WAYS,
    parameter int unsigned SEG_W      = L1TAG_SEG_W,
    parameter logic [9:0]  HIT_DELAY  = L1TAG_HIT_DELAY,
    parameter logic [9:0]  MISS_DELAY = L1TAG_MISS_DELAY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     lookup_valid,
    input  logic [ADDR_W-1:0]        Coalesce2L1_o,
    input  logic [SEG_W-1:0]         SegNum,
    input  logic                     L1TagWrite,
    input  logic [ADDR_W-1:0]        L1TagWriteAddr,
    output logic                     L1_HIT,
    output logic [idx_w(WAYS)-1:0]   hit_way,
    output logic [9:0]               Delay,
    output logic                     resp_valid
`ifdef L1TAG_FLUSH_EN
    ,
    input  logic                     flush,
    output logic                     flush_busy
`endif
);

    localparam int unsigned NSETS = 2 ** SET_W;
    localparam int unsigned IDX_W = idx_w(WAYS);
    localparam int unsigned TAG_W = tag_w(ADDR_W, LINE_W, SET_W, SEG_W);

    logic [WAYS-1:0]                  valid_q [NSETS];
    logic [WAYS-1:0]                  valid_d [NSETS];
    logic [WAYS-1:0][TAG_W-1:0]       tag_q   [NSETS];
    logic [WAYS-1:0][TAG_W-1:0]       tag_d   [NSETS];
    logic [WAYS-1:0][IDX_W-1:0]       age_q   [NSETS];
    logic [WAYS-1:0][IDX_W-1:0]       age_d   [NSETS];

    logic             resp_valid_q, resp_valid_d;
    logic             l1_hit_q, l1_hit_d;
    logic [IDX_W-1:0] hit_way_q, hit_way_d;
    logic [9:0]       delay_q, delay_d;

    logic             flush_active;
    logic [SET_W-1:0] flush_idx;

    logic [SET_W-1:0] lk_set, fl_set;
    logic [TAG_W-1:0] lk_tag, fl_tag;
    logic             lk_hit, fl_hit, lk_touch, fill_en;
    logic [IDX_W-1:0] lk_way, fl_way, fl_touch_way, victim_c;
    logic [WAYS-1:0][IDX_W-1:0] lk_age_c, fl_age_base, fl_age_c;
    logic             unused_c;

    assign lk_set   = Coalesce2L1_o[LINE_W+SET_W-1:LINE_W];
    assign lk_tag   = {SegNum, Coalesce2L1_o[ADDR_W-1:LINE_W+SET_W]};
    assign fl_set   = L1TagWriteAddr[LINE_W+SET_W-1:LINE_W];
    assign fl_tag   = {SegNum, L1TagWriteAddr[ADDR_W-1:LINE_W+SET_W]};
    assign unused_c = ^{Coalesce2L1_o[LINE_W-1:0], L1TagWriteAddr[LINE_W-1:0]};

    // Tag match against pre-fill contents for both ports.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        fl_hit = 1'b0;
        fl_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = IDX_W'(w);
            end
            if (!fl_hit && valid_q[fl_set][w] && tag_q[fl_set][w] == fl_tag) begin
                fl_hit = 1'b1;
                fl_way = IDX_W'(w);
            end
        end
    end

    assign lk_touch     = lookup_valid && !stall && lk_hit && !flush_active;
    assign fill_en      = L1TagWrite && !flush_active;
    assign fl_touch_way = fl_hit ? fl_way : victim_c;
    // A same-set fill starts from the ages already updated by this cycle's lookup.
    assign fl_age_base  = (lk_touch && lk_set == fl_set) ? lk_age_c : age_q[fl_set];

    l1tag_lru_set #(.WAYS(WAYS), .IDX_W(IDX_W)) u_lru_lookup (
        .age_i       (age_q[lk_set]),
        .valid_i     (valid_q[lk_set]),
        .touch_en_i  (lk_touch),
        .touch_way_i (lk_way),
        .age_c       (lk_age_c),
        .victim_c    ()
    );

    l1tag_lru_set #(.WAYS(WAYS), .IDX_W(IDX_W)) u_lru_fill (
        .age_i       (fl_age_base),
        .valid_i     (valid_q[fl_set]),
        .touch_en_i  (fill_en),
        .touch_way_i (fl_touch_way),
        .age_c       (fl_age_c),
        .victim_c    (victim_c)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        age_d   = age_q;
        if (lk_touch) begin
            age_d[lk_set] = lk_age_c;
        end
        if (fill_en) begin
            age_d[fl_set] = fl_age_c;
            if (!fl_hit) begin
                valid_d[fl_set][victim_c] = 1'b1;
                tag_d[fl_set][victim_c]   = fl_tag;
            end
        end
        if (flush_active) begin
            valid_d[flush_idx] = '0;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        l1_hit_d     = l1_hit_q;
        hit_way_d    = hit_way_q;
        delay_d      = delay_q;
        if (!stall) begin
            resp_valid_d = lookup_valid;
            l1_hit_d     = 1'b0;
            hit_way_d    = '0;
            delay_d      = '0;
            if (lookup_valid) begin
                if (lk_hit && !flush_active) begin
                    l1_hit_d  = 1'b1;
                    hit_way_d = lk_way;
                    delay_d   = HIT_DELAY;
                end else begin
                    delay_d   = MISS_DELAY;
                end
            end
        end
    end

    // Reset leaves way i with age i so the LRU order is a valid permutation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= IDX_W'(w);
                end
            end
            resp_valid_q <= 1'b0;
            l1_hit_q     <= 1'b0;
            hit_way_q    <= '0;
            delay_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            age_q        <= age_d;
            resp_valid_q <= resp_valid_d;
            l1_hit_q     <= l1_hit_d;
            hit_way_q    <= hit_way_d;
            delay_q      <= delay_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign resp_valid = resp_valid_q;
    assign L1_HIT     = l1_hit_q;
    assign hit_way    = hit_way_q;
    assign Delay      = delay_q;

`ifdef L1TAG_FLUSH_EN
    flush_state_e     flush_state_q, flush_state_d;
    logic [SET_W-1:0] flush_idx_q, flush_idx_d;
    logic             flush_busy_q, flush_busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_state_q <= FLUSH_IDLE;
            flush_idx_q   <= '0;
            flush_busy_q  <= 1'b0;
        end else begin
            flush_state_q <= flush_state_d;
            flush_idx_q   <= flush_idx_d;
            flush_busy_q  <= flush_busy_d;
        end
    end

    // Walk every set once; flush requests while running are ignored.
    always_comb begin
        flush_state_d = flush_state_q;
        flush_idx_d   = flush_idx_q;
        case (flush_state_q)
            FLUSH_IDLE: begin
                if (flush) begin
                    flush_state_d = FLUSH_RUN;
                    flush_idx_d   = '0;
                end
            end
            FLUSH_RUN: begin
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == SET_W'(NSETS - 1)) begin
                    flush_state_d = FLUSH_IDLE;
                end
            end
            default: flush_state_d = FLUSH_IDLE;
        endcase
    end

    always_comb begin
        flush_busy_d = (flush_state_d == FLUSH_RUN);
    end

    assign flush_active = (flush_state_q == FLUSH_RUN);
    assign flush_idx    = flush_idx_q;
    assign flush_busy   = flush_busy_q;
`else
    assign flush_active = 1'b0;
    assign flush_idx    = '0;
`endif

endmodule
